// File: rtl/uart_mmio_ctrl.sv
`default_nettype none
// ============================================================================
// uart_mmio_ctrl : MEM-stage 8N1 UART peripheral at 0xBFD003F8 (data) and
//                  0xBFD003FC (status); TX launch, RX capture, load return.
// Revision       : 1.0
// ============================================================================
module uart_mmio_ctrl #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  ramOp_i,
  input  logic [31:0] ramAddr_i,
  input  logic [31:0] storeData_i,
  input  logic        stall_i,
  input  logic        uart_rx_i,
  output logic        uart_tx_o,
  output logic        hit_o,
  output logic [31:0] loadData_o,
  output logic        pauseRequest,
  output logic        rxIrq_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  // MEM-stage op encoding shared with the pipeline's defines
  localparam logic [3:0] MEM_NOP = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LBU = 4'd2;
  localparam logic [3:0] MEM_LH  = 4'd3;
  localparam logic [3:0] MEM_LHU = 4'd4;
  localparam logic [3:0] MEM_LW  = 4'd5;
  localparam logic [3:0] MEM_SB  = 4'd6;
  localparam logic [3:0] MEM_SH  = 4'd7;
  localparam logic [3:0] MEM_SW  = 4'd8;

  localparam logic [31:0] ADDR_DATA = 32'hBFD0_03F8;
  localparam logic [31:0] ADDR_STAT = 32'hBFD0_03FC;

  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q,   tx_cnt_d;
  logic [2:0]    tx_bit_q,   tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q,  tx_line_d;

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]    rx_bit_q,   rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [1:0]    rx_sync_q,  rx_sync_d;
  logic [7:0]    rx_data_q,  rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          overrun_q,  overrun_d;
  logic          rx_irq_q,   rx_irq_d;

  logic is_data, is_stat, is_load, is_store, tx_idle, fire;
  logic data_pop, stat_pop, tx_launch, frame_ok, rx_in;
  logic unused_store_hi;

  assign unused_store_hi = ^storeData_i[31:8];

  always_comb begin
    is_data  = (ramAddr_i == ADDR_DATA);
    is_stat  = (ramAddr_i == ADDR_STAT);
    is_load  = (ramOp_i == MEM_LB) || (ramOp_i == MEM_LBU) || (ramOp_i == MEM_LH) ||
               (ramOp_i == MEM_LHU) || (ramOp_i == MEM_LW);
    is_store = (ramOp_i == MEM_SB) || (ramOp_i == MEM_SH) || (ramOp_i == MEM_SW);
    tx_idle  = (tx_state_q == T_IDLE);

    hit_o        = (ramOp_i != MEM_NOP) && (is_data || is_stat);
    pauseRequest = is_store && is_data && !tx_idle;
    fire         = hit_o && !stall_i && !pauseRequest;
    data_pop     = fire && is_load && is_data;
    stat_pop     = fire && is_load && is_stat;
    tx_launch    = fire && is_store && is_data;

    loadData_o = 32'd0;
    if (hit_o && is_load) begin
      if (is_data) loadData_o = {24'd0, rx_data_q};
      else         loadData_o = {29'd0, overrun_q, rx_valid_q, tx_idle};
    end
  end

  // Transmitter: the line register is updated at each state entry so the
  // serial output never sees combinational glitches.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    case (tx_state_q)
      T_IDLE: begin
        if (tx_launch) begin
          tx_state_d = T_START;
          tx_cnt_d   = '0;
          tx_shift_d = storeData_i[7:0];
          tx_line_d  = 1'b0;
        end
      end
      T_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_state_d = T_DATA;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      T_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = T_STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      T_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = T_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    rx_sync_d  = {rx_sync_q[0], uart_rx_i};
    rx_in      = rx_sync_q[1];
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    frame_ok   = 1'b0;
    case (rx_state_q)
      R_IDLE: begin
        if (!rx_in) begin
          rx_state_d = R_START;
          rx_cnt_d   = '0;
        end
      end
      R_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_in ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_in, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      R_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = R_IDLE;
          frame_ok   = rx_in;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = R_IDLE;
    endcase

    // A new frame landing on the same edge as a data pop replaces the popped
    // byte, so it is not an overrun.
    rx_data_d  = frame_ok ? rx_shift_q : rx_data_q;
    rx_valid_d = rx_valid_q;
    if (data_pop) rx_valid_d = 1'b0;
    if (frame_ok) rx_valid_d = 1'b1;
    overrun_d = overrun_q;
    if (stat_pop) overrun_d = 1'b0;
    if (frame_ok && rx_valid_q && !data_pop) overrun_d = 1'b1;
    rx_irq_d = rx_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= T_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_line_q  <= 1'b1;
      rx_state_q <= R_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_sync_q  <= 2'b11;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      rx_irq_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_sync_q  <= rx_sync_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      rx_irq_q   <= rx_irq_d;
    end
  end

  assign uart_tx_o = tx_line_q;
  assign rxIrq_o   = rx_irq_q;

endmodule
`default_nettype wire
